// File: rtl/dmem_controller.sv
// dmem_controller: word-addressed data memory with fixed access latency, CPU stall and access counters
module dmem_controller #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cpu_mem_read,
   input  logic             cpu_mem_write,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   output logic             acc_err,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int WC_W = $clog2(LATENCY + 1);
   localparam logic [WC_W-1:0] LAT = WC_W'(LATENCY);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   state_t state, state_n;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] offset, wdata_r;
   logic [AW-1:0] widx, widx_r;
   logic [WC_W-1:0] wait_cnt;
   logic req, legal, wr_r;
   always_comb begin
      offset = cpu_addr - BASE_ADDR;
      widx = offset[AW+1:2];
      req = cpu_mem_read | cpu_mem_write;
      legal = offset[1:0] == 2'b00 && offset[31:AW+2] == '0;
      cpu_stall = reset_n && (state == S_IDLE ? req && legal : state == S_WAIT);
      state_n = state == S_IDLE ? (req && legal ? S_WAIT : S_IDLE) :
                state == S_WAIT ? (wait_cnt == LAT ? S_DONE : S_WAIT) : S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cpu_rdata <= '0;
         acc_err <= 1'b0;
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         state <= state_n;
         acc_err <= state == S_IDLE && req && (!legal || (cpu_mem_read && cpu_mem_write));
         if (state == S_IDLE) begin
            widx_r <= widx;
            wdata_r <= cpu_wdata;
            wr_r <= cpu_mem_write;
            wait_cnt <= WC_W'(1);
            if (cpu_mem_read && !cpu_mem_write && !legal) cpu_rdata <= '0;
         end
         if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (state == S_WAIT && wait_cnt == LAT && !wr_r) cpu_rdata <= mem[widx_r];
         if (state == S_DONE && wr_r) wr_cnt <= wr_cnt + 1'b1;
         if (state == S_DONE && !wr_r) rd_cnt <= rd_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset_n && state == S_DONE && wr_r) mem[widx_r] <= wdata_r;
   end
endmodule

// File: tb/tb_dmem_controller.sv
// tb_dmem_controller: randomized and directed checks of dmem_controller against a word-array reference model
module tb_dmem_controller;
   localparam int DEPTH = 256;
   localparam int LAT = 2;
   localparam logic [31:0] BASE = 32'h0;
   localparam int CW = 4;
   logic clk = 0, reset_n = 0;
   logic cpu_mem_read = 0, cpu_mem_write = 0;
   logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
   logic cpu_stall, acc_err;
   logic [CW-1:0] rd_cnt, wr_cnt;
   logic [31:0] mm [DEPTH];
   logic [31:0] rdm = 0;
   int rc = 0, wc = 0, n_chk = 0, n_fail = 0;
   dmem_controller #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .acc_err(acc_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_cnts();
      check("rd_cnt", 32'(rd_cnt), 32'(rc % (1 << CW)));
      check("wr_cnt", 32'(wr_cnt), 32'(wc % (1 << CW)));
   endtask
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input bit scr);
      logic [31:0] off;
      bit legal;
      int w;
      off = a - BASE;
      legal = a[1:0] == 2'b00 && (off >> 2) < DEPTH;
      w = int'(off >> 2);
      cpu_mem_read = rd;
      cpu_mem_write = wr;
      cpu_addr = a;
      cpu_wdata = d;
      if (!(rd || wr)) begin
         @(negedge clk);
         check("idle_stall", 32'(cpu_stall), 0);
         check("idle_err", 32'(acc_err), 0);
         @(posedge clk); #1;
      end else if (legal) begin
         for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            check("stall", 32'(cpu_stall), 1);
            check("err", 32'(acc_err), 32'(i == 1 && rd && wr));
            @(posedge clk); #1;
            if (scr) begin
               cpu_addr = $urandom;
               cpu_wdata = $urandom;
            end
         end
         @(negedge clk);
         check("done_stall", 32'(cpu_stall), 0);
         if (!wr) rdm = mm[w];
         check("rdata", cpu_rdata, rdm);
         @(posedge clk); #1;
         if (wr) begin
            mm[w] = d;
            wc++;
         end else rc++;
         check_cnts();
      end else begin
         @(negedge clk);
         check("ill_stall", 32'(cpu_stall), 0);
         check("ill_err_pre", 32'(acc_err), 0);
         @(posedge clk); #1;
         cpu_mem_read = 0;
         cpu_mem_write = 0;
         if (rd && !wr) rdm = 0;
         @(negedge clk);
         check("ill_err", 32'(acc_err), 1);
         check("ill_rdata", cpu_rdata, rdm);
         check_cnts();
         @(posedge clk); #1;
         check("ill_err_end", 32'(acc_err), 0);
      end
   endtask
   initial begin
      cpu_mem_write = 1;
      cpu_addr = 32'h10;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(cpu_stall), 0);
      check("rst_rdata", cpu_rdata, 0);
      check("rst_err", 32'(acc_err), 0);
      check_cnts();
      cpu_mem_write = 0;
      reset_n = 1;
      for (int i = 0; i < DEPTH; i++) access(0, 1, 32'(i * 4), $urandom, 0);
      access(0, 1, 32'h10, 32'hDEADBEEF, 0);
      access(0, 0, 0, 0, 0);
      access(1, 0, 32'h10, 0, 0);
      check("load_beef", cpu_rdata, 32'hDEADBEEF);
      access(1, 0, 32'h13, 0, 0);
      access(0, 1, 32'h0, 32'h0000A5A5, 0);
      access(0, 1, 32'h400, 32'h12345678, 0);
      access(1, 0, 32'h0, 0, 0);
      check("load_a5", cpu_rdata, 32'h0000A5A5);
      access(1, 0, 32'hFFFF_FFFC, 0, 0);
      access(0, 1, 32'h20, 32'h22222222, 0);
      cpu_mem_write = 1;
      cpu_addr = 32'h20;
      cpu_wdata = 32'h11111111;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset_n = 0;
      @(negedge clk);
      check("rst_mid_stall", 32'(cpu_stall), 0);
      @(posedge clk); #1;
      reset_n = 1;
      cpu_mem_write = 0;
      rc = 0;
      wc = 0;
      rdm = 0;
      check_cnts();
      check("rst_mid_rdata", cpu_rdata, 0);
      access(1, 0, 32'h20, 0, 0);
      check("abort_old", cpu_rdata, 32'h22222222);
      access(0, 1, 32'h0, 32'hA0, 0);
      access(0, 1, 32'h4, 32'hA4, 0);
      access(0, 1, 32'h8, 32'hA8, 0);
      check("b2b_wr", 32'(wr_cnt), 3);
      access(1, 1, 32'h8, 32'h5, 0);
      access(1, 0, 32'h8, 0, 0);
      check("both_wr", cpu_rdata, 32'h5);
      rc = 0;
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1;
      wc = 0;
      rdm = 0;
      for (int i = 0; i < 16; i++) access(1, 0, 32'(i * 4), 0, 0);
      check("rd_wrap", 32'(rd_cnt), 0);
      for (int i = 0; i < 300; i++) begin
         int k, op;
         logic [31:0] a;
         k = $urandom_range(0, 9);
         op = $urandom_range(0, 3);
         a = {22'b0, 8'($urandom), 2'b00};
         if (k == 0) a[1:0] = 2'($urandom_range(1, 3));
         if (k == 1) a = $urandom_range(0, 1) ? 32'h400 + 32'($urandom_range(0, 255)) * 4 : 32'hFFFF_FFFC;
         if (k == 2) access(0, 0, a, $urandom, 0);
         else access(op == 0 || op == 2 || op == 3, op == 1 || op == 2, a, $urandom, bit'($urandom_range(0, 1)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_controller.md
Name: dmem_controller

Overview:
Word-addressed data memory with a fixed multi-cycle access latency. It sits directly downstream of the single-cycle CPU core and consumes its mem_address, mem_write_data, mem_read and mem_write outputs. It returns load data and a cpu_stall that freezes the PC and register write-back until the access completes. It also rejects misaligned and out-of-range accesses, and counts completed reads and writes.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the internal array (power of two, ≥4)
LATENCY, 2, wait cycles per access (≥1); total access time is LATENCY+1 cycles
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned)
CNT_W, 16, width of the read and write access counters

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  synchronous, active-low reset
cpu_mem_read  in  1  load request from the CPU (level, held while stalled)
cpu_mem_write  in  1  store request from the CPU (level, held while stalled)
cpu_addr  in  32  byte address (CPU mem_address)
cpu_wdata  in  32  store data (CPU mem_write_data)
cpu_rdata  out  32  load data; valid in the DONE cycle, held until the next completed read
cpu_stall  out  1  high means the CPU must not advance this cycle
acc_err  out  1  one-cycle pulse on a rejected request
rd_cnt  out  CNT_W  completed reads
wr_cnt  out  CNT_W  completed writes

Behaviour:
- Reset (reset_n=0 at a rising edge): state→IDLE; cpu_rdata=0; acc_err=0; rd_cnt=0; wr_cnt=0. cpu_stall=0 while reset_n=0.
- Reset mid-access aborts the access. A pending write is not committed. Array contents are never cleared by reset.
- req = cpu_mem_read | cpu_mem_write. If both are high, the request is a write (write priority) and acc_err pulses. The write still proceeds.
- Legal request: cpu_addr[1:0]==0 and widx=(cpu_addr-BASE_ADDR)>>2 < DEPTH_WORDS. The subtraction is a 32-bit unsigned subtraction, so an address below BASE_ADDR wraps to a large value and is illegal.
- Illegal request, seen in IDLE: cpu_stall=0 (combinational), no array access, no counter change. acc_err=1 in the next cycle for exactly one cycle. cpu_rdata is loaded with 0 if the request was a read.
- FSM states:
  - IDLE: cpu_stall = req & legal (combinational, same cycle). On a legal req, capture widx, cpu_wdata and the write flag, load wait_cnt=1, then go to WAIT.
  - WAIT: cpu_stall=1. If wait_cnt==LATENCY, go to DONE; else wait_cnt++.
  - DONE: cpu_stall=0. At the end of this cycle a write commits to the array and wr_cnt increments; for a read, rd_cnt increments. Next state is always IDLE.
- Read data: cpu_rdata is registered from array[widx] on the WAIT→DONE edge, so it is valid in the DONE cycle. It is unchanged by writes and illegal writes.
- Timing for a legal request first seen in cycle t:
  - cpu_stall=1 in cycles t..t+LATENCY.
  - DONE is cycle t+LATENCY+1; the CPU advances at its end.
  - A back-to-back memory instruction appears in IDLE at t+LATENCY+2 and stalls again immediately.
- Inputs sampled only in IDLE. Changes to cpu_addr or cpu_wdata during WAIT/DONE are ignored.
- Counters wrap modulo 2^CNT_W.
- req=0 in IDLE: no effect, stall 0.

Test Plan:
- Reset then store, LATENCY=2: cpu_mem_write=1, addr=0x10, wdata=0xDEADBEEF → cpu_stall=1 for 3 cycles, 0 in DONE; wr_cnt=1; a later load from 0x10 returns 0xDEADBEEF in its DONE cycle; rd_cnt=1.
- Misaligned load addr=0x13 → cpu_stall stays 0; acc_err=1 for one cycle; cpu_rdata=0; rd_cnt unchanged.
- Out-of-range store addr=0x400 (DEPTH_WORDS=256) → no stall, acc_err pulse; a load from 0x000 still returns its prior value; wr_cnt unchanged.
- Store 0x11111111 to 0x20, assert reset_n=0 during the second WAIT cycle, release, load 0x20 → old value returned (write aborted); counters=0.
- Back-to-back stores to 0x0, 0x4, 0x8 with the CPU holding inputs → each stalls exactly LATENCY+1 cycles with one idle-entry cycle between; wr_cnt=3.
- Both cpu_mem_read and cpu_mem_write high, addr=0x8, wdata=0x5 → acc_err pulse, write completes, wr_cnt increments, rd_cnt unchanged. Also: CNT_W=4 with 16 reads → rd_cnt wraps to 0.
